// File: rtl/fifo_rd_streamer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_streamer_if
//   Groups the two handshakes of fifo_rd_streamer: the synch_fifo read port
//   (fifo_rden / fifo_rddata / fifo_empty) and the downstream valid/ready
//   stream (m_data / m_valid / m_ready).
//
//   master : the streamer's view (drives fifo_rden and the output stream)
//   slave  : the environment's view (FIFO + consumer)
//
//   Parameter FIFO_WIDTH : data word width, must match the attached synch_fifo.
// -----------------------------------------------------------------------------
interface fifo_rd_streamer_if #(
  parameter int FIFO_WIDTH = 32
);
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_rddata;
  logic                  fifo_rden;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_rddata, m_ready,
    output fifo_rden,  m_data,      m_valid
  );

  modport slave (
    output fifo_empty, fifo_rddata, m_ready,
    input  fifo_rden,  m_data,      m_valid
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// -----------------------------------------------------------------------------
// fifo_rd_streamer
//   Drains a synch_fifo through its read port and presents the words on a
//   valid/ready stream. A 3-entry circular buffer absorbs the FIFO's one-cycle
//   read latency, so the block sustains one word per cycle while m_ready has
//   no combinational path to fifo_rden.
//
// Ports
//   fifo_clk    : clock shared with synch_fifo, rising edge
//   rst         : asynchronous, active-low reset
//   enable      : 1 = fetch from FIFO, 0 = stop fetching and drain held words
//   busy        : state != IDLE
//   rd_word_cnt : delivered-word counter (only with FIFO_RD_STREAMER_CNT_EN)
//   bus         : fifo_rd_streamer_if.master (FIFO read port + output stream)
//
// Optional feature
//   `define FIFO_RD_STREAMER_CNT_EN adds rd_word_cnt[CNT_WIDTH-1:0], which
//   counts pops modulo 2^CNT_WIDTH.
// -----------------------------------------------------------------------------
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 fifo_clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 busy,
`ifdef FIFO_RD_STREAMER_CNT_EN
  output logic [CNT_WIDTH-1:0] rd_word_cnt,
`endif
  fifo_rd_streamer_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEPTH = 3;

  // Elaboration-time sanity check on the configuration.
  if (CNT_WIDTH < 1 || $bits(bus.fifo_rddata) != FIFO_WIDTH) begin : g_param_check
    $error("fifo_rd_streamer: bad CNT_WIDTH or interface width mismatch");
  end

  state_t                r_state;
  logic                  r_busy;
  logic                  r_inflight;
  logic [1:0]            r_occ;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [FIFO_WIDTH-1:0] r_buf [DEPTH];

  logic [2:0]            w_level;
  logic                  w_rden;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words held plus the one possibly in flight; reads stop once the buffer
  // could not take every outstanding word, which makes overflow impossible.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_rden  = (r_state == RUN) && !bus.fifo_empty && (w_level < 3'd3);
  assign w_push  = r_inflight;
  assign w_pop   = bus.m_valid && bus.m_ready;

  assign bus.fifo_rden = w_rden;
  assign bus.m_valid   = (r_occ != 2'd0);
  // Head comes straight from storage: no bypass from fifo_rddata.
  assign bus.m_data    = r_buf[r_rd_ptr];
  assign busy          = r_busy;

  // Control FSM; busy is registered alongside the state it mirrors.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) r_state <= DRAIN;
        end
        DRAIN: begin
          if (enable) begin
            r_state <= RUN;
          end else if (w_level == 3'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Buffer, pointers, occupancy and the read-latency tracker.
  // NOTE: the 3-word buffer is reset on purpose so m_data reads 0 out of
  // reset; larger memories would normally be left unreset.
  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_inflight <= w_rden;
      if (w_push) begin
        r_buf[r_wr_ptr] <= bus.fifo_rddata;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_RD_STREAMER_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge fifo_clk or negedge rst) begin
    if (!rst)       r_cnt <= '0;
    else if (w_pop) r_cnt <= r_cnt + 1'b1;
  end

  assign rd_word_cnt = r_cnt;
`endif

  // A push into a full buffer would mean the read throttle is broken.
  a_no_overflow : assert property (@(posedge fifo_clk) disable iff (!rst)
    !(w_push && r_occ == 2'd3));

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic busy;
`ifdef FIFO_RD_STREAMER_CNT_EN
  logic [3:0] rd_word_cnt;
`endif

  fifo_rd_streamer_if #(.FIFO_WIDTH(32)) bus ();

  fifo_rd_streamer #(
    .FIFO_WIDTH (32),
    .CNT_WIDTH  (4)
  ) dut (
    .fifo_clk    (clk),
    .rst         (rst),
    .enable      (enable),
    .busy        (busy),
`ifdef FIFO_RD_STREAMER_CNT_EN
    .rd_word_cnt (rd_word_cnt),
`endif
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] fifo_q [$];  // words inside the modelled synch_fifo
  logic [31:0] wr_q   [$];  // writes pending for the next FIFO edge
  logic [31:0] exp_q  [$];  // scoreboard: expected output order

  int rd_cnt    = 0;
  int pop_cnt   = 0;
  int max_level = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive point: just after the active edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [31:0] w);
    wr_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check(name, done, 1'b1);
    next_cycle();
  endtask

  // synch_fifo model: read data appears the cycle after fifo_rden, writes
  // land at the edge after they are requested.
  initial begin
    bus.fifo_empty  = 1'b1;
    bus.fifo_rddata = '0;
    forever begin
      @(posedge clk);
      if (bus.fifo_rden) begin
        check("rd_while_empty", fifo_q.size() != 0, 1'b1);
        if (fifo_q.size() != 0) bus.fifo_rddata <= fifo_q.pop_front();
      end
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: scoreboard compare on every pop, hold check while stalled,
  // outstanding-word bound (occupancy + inflight).
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    int          level;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_stall) check("hold_stable", {bus.m_valid, bus.m_data}, {1'b1, prev_data});
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) check("unexpected_word", bus.m_data, 64'hDEAD);
          else check("data_order", bus.m_data, exp_q.pop_front());
        end
        level = rd_cnt - pop_cnt;
        if (level > max_level) max_level = level;
        if (bus.fifo_rden) rd_cnt++;
        if (bus.m_valid && bus.m_ready) pop_cnt++;
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  rd_vec;
    logic [8:0]  v_vec;
    int          rd0;
    int          pop0;
    logic        b6;
    logic        b8;

    rst          = 1'b0;
    enable       = 1'b1;
    bus.m_ready  = 1'b1;
    #1;

    // ---- reset: FIFO holds data, enable high, nothing may move ----
    fifo_write(32'hA1);
    fifo_write(32'hA2);
    fifo_write(32'hA3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("reset_quiet", {bus.fifo_rden, bus.m_valid, busy}, 3'b000);
      next_cycle();
    end
    check("reset_m_data", bus.m_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rden_after_rst_c0", bus.fifo_rden, 1'b0);
    next_cycle();
    @(negedge clk);
    check("rden_after_rst_c1", bus.fifo_rden, 1'b1);
    repeat (8) next_cycle();
    enable = 1'b0;
    wait_idle("reset_drain");

    // ---- basic latency: 5 words, enable rises in cycle 0 ----
    fifo_write(32'h11);
    fifo_write(32'h22);
    fifo_write(32'h33);
    fifo_write(32'h44);
    fifo_write(32'h55);
    repeat (3) next_cycle();
    enable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rd_vec[c] = bus.fifo_rden;
      v_vec[c]  = bus.m_valid;
      next_cycle();
    end
    check("latency_rden_cycles", rd_vec, 9'h03E);   // cycles 1..5
    check("latency_valid_cycles", v_vec, 9'h0F8);   // cycles 3..7
    enable = 1'b0;
    wait_idle("latency_drain");

    // ---- backpressure: 8 words, m_ready low ----
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_write(32'hB0 + i);
    repeat (2) next_cycle();
    rd0    = rd_cnt;
    enable = 1'b1;
    repeat (12) next_cycle();
    check("bp_three_reads", rd_cnt - rd0, 3);
    check("bp_head_word", {bus.m_valid, bus.m_data}, {1'b1, 32'hB0});
    pop0        = pop_cnt;
    bus.m_ready = 1'b1;
    repeat (8) next_cycle();
    check("bp_one_per_cycle", pop_cnt - pop0, 8);
    enable = 1'b0;
    wait_idle("bp_drain");

    // ---- enable drop after 4 reads, then resume ----
    for (int i = 0; i < 10; i++) fifo_write(32'hC0 + i);
    repeat (2) next_cycle();
    rd0    = rd_cnt;
    pop0   = pop_cnt;
    enable = 1'b1;                 // cycle 0
    repeat (4) next_cycle();
    enable = 1'b0;                 // cycle 4: fourth read still issues
    repeat (2) next_cycle();
    @(negedge clk);
    b6 = busy;                     // cycle 6: last pop
    repeat (2) next_cycle();
    @(negedge clk);
    b8 = busy;                     // cycle 8: back in IDLE
    repeat (4) next_cycle();
    check("drop_reads", rd_cnt - rd0, 4);
    check("drop_pops", pop_cnt - pop0, 4);
    check("drop_busy_at_last_pop", b6, 1'b1);
    check("drop_busy_after", b8, 1'b0);
    check("drop_fifo_left", fifo_q.size(), 6);
    enable = 1'b1;
    repeat (15) next_cycle();
    enable = 1'b0;
    wait_idle("drop_resume_drain");
    check("drop_total_pops", pop_cnt - pop0, 10);

    // ---- alternating m_ready with a continuous write stream ----
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i < 20) fifo_write($urandom);
      bus.m_ready = (i % 2 == 0);
      next_cycle();
    end
    bus.m_ready = 1'b1;
    repeat (5) next_cycle();
    enable = 1'b0;
    wait_idle("alt_drain");
    check("max_outstanding_le3", max_level <= 3, 1'b1);

    // 3 + 5 + 8 + 10 + 20 words delivered in total
    check("total_words", pop_cnt, 46);
`ifdef FIFO_RD_STREAMER_CNT_EN
    check("rd_word_cnt_wrap", rd_word_cnt, 4'd14);  // 46 mod 16
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
